// File: rtl/nandy_io_port.sv
// nandy_io_port: buffered core I/O port with TX/RX byte FIFOs; define NANDY_IO_STALL_EN to stall on full/empty instead of flagging errors.
module nandy_io_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ior,
  input  logic       iow,
  input  logic       port,
  input  logic [7:0] ioout,
  output logic [7:0] ioin,
  output logic       stall,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic ovf, unf;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wr_data, rd_data, rd_stat, wr_stat;
  logic tx_push, tx_pop, rx_push, rx_pop, ovf_set, unf_set;
  logic [7:0] status;
  always_comb begin
    tx_empty = tx_wp == tx_rp;
    rx_empty = rx_wp == rx_rp;
    tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    wr_data  = iow & ~port & ~rst;
    wr_stat  = iow & port & ~rst;
    rd_data  = ior & ~iow & ~port & ~rst;
    rd_stat  = ior & ~iow & port & ~rst;
    tx_valid = ~tx_empty;
    tx_data  = tx_mem[tx_rp[AW-1:0]];
    rx_ready = ~rx_full & ~rst;
    tx_pop   = tx_valid & tx_ready;
    rx_push  = rx_valid & rx_ready;
    tx_push  = wr_data & ~tx_full;
    rx_pop   = rd_data & ~rx_empty;
`ifdef NANDY_IO_STALL_EN
    stall    = (wr_data & tx_full) | (rd_data & rx_empty);
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
`else
    stall    = 1'b0;
    ovf_set  = wr_data & tx_full;
    unf_set  = rd_data & rx_empty;
`endif
    status   = {4'b0, unf, ovf, ~rx_empty, ~tx_full};
    ioin     = rx_pop ? rx_mem[rx_rp[AW-1:0]] : rd_stat ? status : 8'h00;
    err      = ovf | unf;
  end
  // Full/empty above are pre-edge, so a same-cycle opposite-side transfer never rescues an access.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp[AW-1:0]] <= ioout;
        tx_wp <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      if (rx_push) begin
        rx_mem[rx_wp[AW-1:0]] <= rx_data;
        rx_wp <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      ovf <= ovf_set | (ovf & ~(wr_stat & ioout[2]));
      unf <= unf_set | (unf & ~(wr_stat & ioout[3]));
    end
  end
endmodule

// File: tb/tb_nandy_io_port.sv
// tb_nandy_io_port: directed self-checking bench for nandy_io_port (either build).
module tb_nandy_io_port;
  logic clk = 0, rst = 1, ior = 0, iow = 0, port = 0, tx_ready = 0, rx_valid = 0;
  logic [7:0] ioout = 0, rx_data = 0;
  logic [7:0] ioin, tx_data;
  logic stall, tx_valid, rx_ready, err;
  int n_cmp = 0, n_bad = 0;
  nandy_io_port dut (
    .clk(clk), .rst(rst), .ior(ior), .iow(iow), .port(port), .ioout(ioout),
    .ioin(ioin), .stall(stall), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .err(err)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic write_tx(input logic [7:0] v);
    iow = 1; port = 0; ioout = v;
    cyc();
    iow = 0; ioout = 0;
  endtask
  task automatic push_rx(input logic [7:0] v);
    rx_valid = 1; rx_data = v;
    cyc();
    rx_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1; iow = 1; ioout = 8'h77;
    cyc(); cyc();
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rx_ready got %b exp 0", rx_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", stall); end
    n_cmp++; if (ioin !== 8'h00) begin n_bad++; $display("FAIL rst_ioin got %h exp 00", ioin); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err); end
    iow = 0; ioout = 0; rst = 0;
    cyc();
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_rx_ready got %b exp 1", rx_ready); end
    ior = 1; port = 1; #1;
    n_cmp++; if (ioin !== 8'h01) begin n_bad++; $display("FAIL post_rst_status got %h exp 01", ioin); end
    ior = 0; port = 0;
  endtask
  task automatic test_tx_fifo();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) write_tx(exp[i]);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin n_bad++; $display("FAIL tx_head got %b/%h exp 1/11", tx_valid, tx_data); end
    ior = 1; port = 1; #1;
    n_cmp++; if (ioin !== 8'h00) begin n_bad++; $display("FAIL tx_full_status got %h exp 00", ioin); end
    ior = 0; port = 0;
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tx_data !== exp[i]) begin n_bad++; $display("FAIL tx_drain%0d got %h exp %h", i, tx_data, exp[i]); end
      cyc();
    end
    tx_ready = 0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_drained_valid got %b exp 0", tx_valid); end
  endtask
  task automatic test_tx_full();
`ifdef NANDY_IO_STALL_EN
    logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
`else
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    for (int i = 1; i <= 4; i++) write_tx(8'(i * 8'h11));
    iow = 1; port = 0; ioout = 8'h55; #1;
`ifdef NANDY_IO_STALL_EN
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got %b exp 1", stall); end
    cyc();
    n_cmp++; if (stall !== 1'b1 || tx_data !== 8'h11) begin n_bad++; $display("FAIL full_hold got %b/%h exp 1/11", stall, tx_data); end
    tx_ready = 1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_pop_cycle_stall got %b exp 1", stall); end
    cyc();
    tx_ready = 0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL full_release got %b exp 0", stall); end
    cyc();
    iow = 0; ioout = 0;
`else
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nostall got %b exp 0", stall); end
    cyc();
    iow = 0; ioout = 0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b exp 1", err); end
    ior = 1; port = 1; #1;
    n_cmp++; if (ioin !== 8'h04) begin n_bad++; $display("FAIL ovf_status got %h exp 04", ioin); end
    ior = 0;
    iow = 1; ioout = 8'h04;
    cyc();
    iow = 0; ioout = 0; ior = 1; #1;
    n_cmp++; if (ioin !== 8'h00 || err !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %h/%b exp 00/0", ioin, err); end
    ior = 0; port = 0;
`endif
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin n_bad++; $display("FAIL full_drain%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, exp[i]); end
      cyc();
    end
    tx_ready = 0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL full_drained got %b exp 0", tx_valid); end
  endtask
  task automatic test_rx();
    push_rx(8'hA5);
    push_rx(8'h5A);
    ior = 1; port = 1; #1;
    n_cmp++; if (ioin !== 8'h03) begin n_bad++; $display("FAIL rx_status got %h exp 03", ioin); end
    port = 0; #1;
    n_cmp++; if (ioin !== 8'hA5) begin n_bad++; $display("FAIL rx_read0 got %h exp a5", ioin); end
    cyc();
    n_cmp++; if (ioin !== 8'h5A) begin n_bad++; $display("FAIL rx_read1 got %h exp 5a", ioin); end
    cyc();
    port = 1; #1;
    n_cmp++; if (ioin !== 8'h01) begin n_bad++; $display("FAIL rx_empty_status got %h exp 01", ioin); end
    ior = 0; port = 0; #1;
    n_cmp++; if (ioin !== 8'h00) begin n_bad++; $display("FAIL idle_ioin got %h exp 00", ioin); end
  endtask
  task automatic test_rx_empty();
    ior = 1; port = 0; #1;
`ifdef NANDY_IO_STALL_EN
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL empty_stall got %b exp 1", stall); end
    cyc();
    rx_valid = 1; rx_data = 8'hC3; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL empty_push_cycle_stall got %b exp 1", stall); end
    cyc();
    rx_valid = 0; #1;
    n_cmp++; if (stall !== 1'b0 || ioin !== 8'hC3) begin n_bad++; $display("FAIL empty_release got %b/%h exp 0/c3", stall, ioin); end
    cyc();
    port = 1; #1;
    n_cmp++; if (ioin !== 8'h01) begin n_bad++; $display("FAIL empty_after got %h exp 01", ioin); end
    ior = 0; port = 0;
`else
    n_cmp++; if (ioin !== 8'h00) begin n_bad++; $display("FAIL unf_ioin got %h exp 00", ioin); end
    cyc();
    port = 1; #1;
    n_cmp++; if (ioin !== 8'h09 || err !== 1'b1) begin n_bad++; $display("FAIL unf_status got %h/%b exp 09/1", ioin, err); end
    ior = 0; iow = 1; ioout = 8'h08;
    cyc();
    iow = 0; ioout = 0; ior = 1; #1;
    n_cmp++; if (ioin !== 8'h01) begin n_bad++; $display("FAIL unf_clear got %h exp 01", ioin); end
    ior = 0; port = 0;
`endif
  endtask
  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) push_rx(8'(i));
    rx_valid = 1; rx_data = 8'h05; ior = 1; port = 0; #1;
    n_cmp++; if (rx_ready !== 1'b0 || ioin !== 8'h01) begin n_bad++; $display("FAIL b2b_full got %b/%h exp 0/01", rx_ready, ioin); end
    cyc();
    ior = 0; #1;
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b exp 1", rx_ready); end
    cyc();
    rx_valid = 0; ior = 1;
    for (int i = 2; i <= 5; i++) begin
      #1;
      n_cmp++; if (ioin !== 8'(i)) begin n_bad++; $display("FAIL b2b_read%0d got %h exp %h", i, ioin, 8'(i)); end
      cyc();
    end
    port = 1; #1;
    n_cmp++; if (ioin !== 8'h01) begin n_bad++; $display("FAIL b2b_empty got %h exp 01", ioin); end
    ior = 0; port = 0;
  endtask
  task automatic test_reset_mid();
    write_tx(8'hAA);
    write_tx(8'hBB);
    push_rx(8'h99);
    rst = 1; iow = 1; ioout = 8'hCC; rx_valid = 1; rx_data = 8'h66; #1;
    n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rx_ready got %b exp 0", rx_ready); end
    cyc();
    rst = 0; iow = 0; ioout = 0; rx_valid = 0; #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tx_valid got %b exp 0", tx_valid); end
    ior = 1; port = 1; #1;
    n_cmp++; if (ioin !== 8'h01) begin n_bad++; $display("FAIL mid_rst_status got %h exp 01", ioin); end
    ior = 0; port = 0;
  endtask
  initial begin
    #1;
    test_reset();
    test_tx_fifo();
    test_tx_full();
    test_rx();
    test_rx_empty();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
